// File: rtl/sys_ctrl_gen2.sv
// sys_ctrl_gen2: UART-frame command decoder driving register file, ALU and TX FIFO
// Ports:
//   CLK, RST                     clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD          received frame byte and its strobe
//   RdData, RdData_Valid         register-file read return
//   FIFO_FULL                    TX FIFO back-pressure
//   ALU_OUT, ALU_OUT_VLD         ALU result return
//   ALU_FUN, ALU_EN, GATE_EN     ALU function, start pulse, clock-gate enable
//   TX_DATA, TX_VLD              TX FIFO write
//   Address, WrEn, RdEn, WrData  register-file access
//   BUSY                         frame in progress
//   ERR_PULSE                    error event pulse (only with SYS_CTRL_ERR_RESP_EN)
// Optional feature macro SYS_CTRL_ERR_RESP_EN: push 0xEE on unknown command or timeout.
// All outputs are registered from the next-state logic.
module sys_ctrl_gen2 #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   RX_P_DATA,
  input  logic                RX_D_VLD,
  input  logic [DATA_W-1:0]   RdData,
  input  logic                RdData_Valid,
  input  logic                FIFO_FULL,
  input  logic [2*DATA_W-1:0] ALU_OUT,
  input  logic                ALU_OUT_VLD,
  output logic [FUN_W-1:0]    ALU_FUN,
  output logic                ALU_EN,
  output logic                GATE_EN,
  output logic [DATA_W-1:0]   TX_DATA,
  output logic                TX_VLD,
  output logic [ADDR_W-1:0]   Address,
  output logic                WrEn,
  output logic                RdEn,
  output logic [DATA_W-1:0]   WrData,
  output logic                BUSY
`ifdef SYS_CTRL_ERR_RESP_EN
  ,output logic               ERR_PULSE
`endif
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, PUSH, BR_ADDR, BR_CNT,
    ALU_A, ALU_B, ALU_F, ALU_WAIT, PUSH_LO, PUSH_HI
`ifdef SYS_CTRL_ERR_RESP_EN
    , ERR_PUSH
`endif
  } state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);
`ifdef SYS_CTRL_ERR_RESP_EN
  localparam logic [DATA_W-1:0] ERR_BYTE = DATA_W'(8'hEE);
  logic err_n;
`endif
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_r, addr_n, address_n;
  logic [DATA_W-1:0] cnt_r, cnt_n, wr_data_n, tx_data_n;
  logic [2*DATA_W-1:0] res_r, res_n;
  logic [CNT_W-1:0] tmo, tmo_n;
  logic [FUN_W-1:0] fun_n;
  logic wr_n, rd_n, alu_en_n, tx_vld_n, gate_n, waiting, strobe, abort;
  logic [ADDR_W-1:0] rx_addr;
  assign rx_addr = RX_P_DATA[ADDR_W-1:0];
  assign waiting = state inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, BR_ADDR, BR_CNT, ALU_A, ALU_B, ALU_F};
  assign strobe  = (state == RD_WAIT) ? RdData_Valid : RX_D_VLD;
  assign abort   = (TIMEOUT_CYC != 0) && waiting && !strobe && (tmo == TO_LAST);
  always_comb begin
    state_n = state;
    addr_n = addr_r;
    cnt_n = cnt_r;
    res_n = res_r;
    address_n = Address;
    wr_data_n = WrData;
    tx_data_n = TX_DATA;
    fun_n = ALU_FUN;
    gate_n = GATE_EN;
    wr_n = 1'b0;
    rd_n = 1'b0;
    alu_en_n = 1'b0;
    tx_vld_n = 1'b0;
`ifdef SYS_CTRL_ERR_RESP_EN
    err_n = 1'b0;
`endif
    case (state)
      IDLE: if (RX_D_VLD) begin
        if (RX_P_DATA == DATA_W'(8'hAA)) state_n = WR_ADDR;
        else if (RX_P_DATA == DATA_W'(8'hBB)) state_n = RD_ADDR;
        else if (RX_P_DATA == DATA_W'(8'hCC)) state_n = ALU_A;
        else if (RX_P_DATA == DATA_W'(8'hDD)) begin
          state_n = ALU_F;
          gate_n = 1'b1;
        end
        else if (RX_P_DATA == DATA_W'(8'hEE)) state_n = BR_ADDR;
`ifdef SYS_CTRL_ERR_RESP_EN
        else begin
          state_n = ERR_PUSH;
          err_n = 1'b1;
        end
`endif
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_n = rx_addr;
        state_n = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_n = 1'b1;
        address_n = addr_r;
        wr_data_n = RX_P_DATA;
        state_n = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_n = rx_addr;
        address_n = rx_addr;
        cnt_n = DATA_W'(1);
        rd_n = 1'b1;
        state_n = RD_WAIT;
      end
      BR_ADDR: if (RX_D_VLD) begin
        addr_n = rx_addr;
        state_n = BR_CNT;
      end
      BR_CNT: if (RX_D_VLD) begin
        if (RX_P_DATA == '0) state_n = IDLE;
        else begin
          cnt_n = RX_P_DATA;
          address_n = addr_r;
          rd_n = 1'b1;
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: if (RdData_Valid) begin
        res_n = {{DATA_W{1'b0}}, RdData};
        state_n = PUSH;
      end
      // each pushed byte of a burst launches the next read in the same cycle
      PUSH: if (!FIFO_FULL) begin
        tx_vld_n = 1'b1;
        tx_data_n = res_r[DATA_W-1:0];
        if (cnt_r > DATA_W'(1)) begin
          cnt_n = cnt_r - 1'b1;
          addr_n = addr_r + 1'b1;
          address_n = addr_r + 1'b1;
          rd_n = 1'b1;
          state_n = RD_WAIT;
        end
        else state_n = IDLE;
      end
      ALU_A: if (RX_D_VLD) begin
        wr_n = 1'b1;
        address_n = ADDR_W'(OPA_ADDR);
        wr_data_n = RX_P_DATA;
        state_n = ALU_B;
      end
      ALU_B: if (RX_D_VLD) begin
        wr_n = 1'b1;
        address_n = ADDR_W'(OPB_ADDR);
        wr_data_n = RX_P_DATA;
        gate_n = 1'b1;
        state_n = ALU_F;
      end
      ALU_F: if (RX_D_VLD) begin
        fun_n = RX_P_DATA[FUN_W-1:0];
        alu_en_n = 1'b1;
        state_n = ALU_WAIT;
      end
      // a valid coincident with our own ALU_EN pulse is stale and ignored
      ALU_WAIT: if (ALU_OUT_VLD && !ALU_EN) begin
        res_n = ALU_OUT;
        state_n = PUSH_LO;
      end
      PUSH_LO: if (!FIFO_FULL) begin
        tx_vld_n = 1'b1;
        tx_data_n = res_r[DATA_W-1:0];
        state_n = PUSH_HI;
      end
      PUSH_HI: if (!FIFO_FULL) begin
        tx_vld_n = 1'b1;
        tx_data_n = res_r[2*DATA_W-1:DATA_W];
        gate_n = 1'b0;
        state_n = IDLE;
      end
`ifdef SYS_CTRL_ERR_RESP_EN
      ERR_PUSH: if (!FIFO_FULL) begin
        tx_vld_n = 1'b1;
        tx_data_n = ERR_BYTE;
        state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    tmo_n = (!waiting || strobe || state_n != state) ? '0 : tmo + 1'b1;
    if (abort) begin
      gate_n = 1'b0;
      tmo_n = '0;
`ifdef SYS_CTRL_ERR_RESP_EN
      state_n = ERR_PUSH;
      err_n = 1'b1;
`else
      state_n = IDLE;
`endif
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      addr_r <= '0;
      cnt_r <= '0;
      res_r <= '0;
      tmo <= '0;
      ALU_FUN <= '0;
      ALU_EN <= 1'b0;
      GATE_EN <= 1'b0;
      TX_DATA <= '0;
      TX_VLD <= 1'b0;
      Address <= '0;
      WrEn <= 1'b0;
      RdEn <= 1'b0;
      WrData <= '0;
      BUSY <= 1'b0;
`ifdef SYS_CTRL_ERR_RESP_EN
      ERR_PULSE <= 1'b0;
`endif
    end
    else begin
      state <= state_n;
      addr_r <= addr_n;
      cnt_r <= cnt_n;
      res_r <= res_n;
      tmo <= tmo_n;
      ALU_FUN <= fun_n;
      ALU_EN <= alu_en_n;
      GATE_EN <= gate_n;
      TX_DATA <= tx_data_n;
      TX_VLD <= tx_vld_n;
      Address <= address_n;
      WrEn <= wr_n;
      RdEn <= rd_n;
      WrData <= wr_data_n;
      BUSY <= (state_n != IDLE);
`ifdef SYS_CTRL_ERR_RESP_EN
      ERR_PULSE <= err_n;
`endif
    end
  end
endmodule
